// File: rtl/pic8259_pkg.sv
// pic8259_pkg: definitions shared by the 8259A control-logic blocks.
//   PIC_DATA_WIDTH : width of the internal data bus and of each mask register.
//   pic_byte_t     : one data-bus byte, bit n = IRn.
//   PIC_MASK_CLEAR : value a mask register takes on reset or ICW1.
package pic8259_pkg;
  localparam int PIC_DATA_WIDTH = 8;
  typedef logic [PIC_DATA_WIDTH-1:0] pic_byte_t;
  localparam pic_byte_t PIC_MASK_CLEAR = '0;
endpackage

// File: rtl/pic_mask_reg.sv
// pic_mask_reg: DATA_WIDTH load/clear register. A synchronous clear takes
// priority over a load. Otherwise the register holds its value.
// Ports:
//   clock : rising-edge clock
//   clear : synchronous clear (reset or ICW1 is folded in by the parent)
//   load  : load d this edge
//   d     : load data
//   q     : register contents
module pic_mask_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge clock) begin
    if (clear)     q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/ocw1_mask_registers.sv
// ocw1_mask_registers: 8259A interrupt mask register (IMR) and special mask
// register (ISMR), loaded by OCW1 writes and cleared by reset or ICW1.
// special_mask_mode, sampled with the OCW1 strobe, picks the target register.
// Optional macro OCW1_EFFECTIVE_MASK_EN adds a registered effective_mask
// output: IMR | ISMR when special_mask_mode=1, otherwise IMR.
// Ports:
//   clock, reset                              : clock, sync active-high reset
//   write_initial_command_word_1              : ICW1 strobe (clears both)
//   write_operation_control_word_1_registers  : OCW1 strobe
//   special_mask_mode                         : 0 -> IMR, 1 -> ISMR
//   internal_data_bus                         : OCW1 data, bit n = IRn
//   interrupt_mask / interrupt_special_mask   : IMR / ISMR contents
//   effective_mask (optional)                 : combined mask, registered
module ocw1_mask_registers
  import pic8259_pkg::*;
#(
  parameter int DATA_WIDTH = PIC_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_initial_command_word_1,
  input  logic                  write_operation_control_word_1_registers,
  input  logic                  special_mask_mode,
  input  logic [DATA_WIDTH-1:0] internal_data_bus,
  output logic [DATA_WIDTH-1:0] interrupt_mask,
  output logic [DATA_WIDTH-1:0] interrupt_special_mask
`ifdef OCW1_EFFECTIVE_MASK_EN
  ,
  output logic [DATA_WIDTH-1:0] effective_mask
`endif
);
  localparam int NUM_REGS = 2;
  localparam int IMR_IDX  = 0;
  localparam int ISMR_IDX = 1;

  logic                                 clear;
  logic [NUM_REGS-1:0]                  load;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  q;

  // Reset and ICW1 share the clear path; the sub-register gives clear
  // priority over load, so ICW1 beats a simultaneous OCW1.
  assign clear          = reset | write_initial_command_word_1;
  assign load[IMR_IDX]  = write_operation_control_word_1_registers & ~special_mask_mode;
  assign load[ISMR_IDX] = write_operation_control_word_1_registers &  special_mask_mode;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    pic_mask_reg #(.DATA_WIDTH(DATA_WIDTH)) u_reg (
      .clock (clock),
      .clear (clear),
      .load  (load[r]),
      .d     (internal_data_bus),
      .q     (q[r])
    );
  end

  assign interrupt_mask         = q[IMR_IDX];
  assign interrupt_special_mask = q[ISMR_IDX];

`ifdef OCW1_EFFECTIVE_MASK_EN
  // Built from the values the two registers take on this same edge, so the
  // combined mask never lags the registers it is derived from.
  logic [DATA_WIDTH-1:0] imr_next, ismr_next;

  always_comb begin
    imr_next  = load[IMR_IDX]  ? internal_data_bus : q[IMR_IDX];
    ismr_next = load[ISMR_IDX] ? internal_data_bus : q[ISMR_IDX];
  end

  always_ff @(posedge clock) begin
    if (clear)                  effective_mask <= '0;
    else if (special_mask_mode) effective_mask <= imr_next | ismr_next;
    else                        effective_mask <= imr_next;
  end
`endif
endmodule

// File: tb/tb_ocw1_mask_registers.sv
// tb_ocw1_mask_registers: directed bench for ocw1_mask_registers with a
// per-cycle reference model and hand-computed literal checks.
module tb_ocw1_mask_registers;
  logic       clock = 1'b0;
  logic       reset;
  logic       icw1;
  logic       ocw1;
  logic       mode;
  logic [7:0] bus;
  logic [7:0] imr, ismr;
`ifdef OCW1_EFFECTIVE_MASK_EN
  logic [7:0] eff;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ocw1_mask_registers #(.DATA_WIDTH(8)) dut (
    .clock                                   (clock),
    .reset                                   (reset),
    .write_initial_command_word_1            (icw1),
    .write_operation_control_word_1_registers(ocw1),
    .special_mask_mode                       (mode),
    .internal_data_bus                       (bus),
    .interrupt_mask                          (imr),
    .interrupt_special_mask                  (ismr)
`ifdef OCW1_EFFECTIVE_MASK_EN
    ,
    .effective_mask                          (eff)
`endif
  );

  // Reference model: the two mask bytes as plain variables, updated from
  // the inputs seen at each rising edge.
  logic [7:0] m_imr, m_ismr, m_eff;
  logic       armed = 1'b0;

  always @(posedge clock) begin
    logic [7:0] ni, ns;
    ni = m_imr;
    ns = m_ismr;
    if (reset || icw1) begin
      ni = 8'h00;
      ns = 8'h00;
    end else if (ocw1) begin
      if (mode) ns = bus;
      else      ni = bus;
    end
    m_imr  <= ni;
    m_ismr <= ns;
    m_eff  <= (reset || icw1) ? 8'h00 : (mode ? (ni | ns) : ni);
    if (reset) armed <= 1'b1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (armed) begin
      chk("model_imr", imr, m_imr);
      chk("model_ismr", ismr, m_ismr);
`ifdef OCW1_EFFECTIVE_MASK_EN
      chk("model_eff", eff, m_eff);
`endif
    end
  end

  // Apply one cycle of inputs, then return just after the following negedge.
  task automatic cyc(input logic r, input logic i, input logic o,
                     input logic m, input logic [7:0] b);
    reset = r; icw1 = i; ocw1 = o; mode = m; bus = b;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; icw1 = 1'b0; ocw1 = 1'b0; mode = 1'b0; bus = 8'h00;
    @(negedge clock);
    cyc(1, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);
    chk("reset_imr", imr, 8'h00);
    chk("reset_ismr", ismr, 8'h00);

    cyc(0, 0, 1, 0, 8'h0F);
    chk("ocw1_imr_0F", imr, 8'h0F);
    chk("ocw1_ismr_hold", ismr, 8'h00);

    cyc(0, 0, 1, 1, 8'hF0);
    chk("ocw1_ismr_F0", ismr, 8'hF0);
    chk("ocw1_imr_hold", imr, 8'h0F);
`ifdef OCW1_EFFECTIVE_MASK_EN
    chk("eff_mode1", eff, 8'hFF);
    cyc(0, 0, 0, 0, 8'h00);
    chk("eff_mode0", eff, 8'h0F);
    cyc(0, 0, 0, 1, 8'h00);
    chk("eff_mode1_again", eff, 8'hFF);
`endif

    cyc(0, 1, 0, 0, 8'h00);
    chk("icw1_imr", imr, 8'h00);
    chk("icw1_ismr", ismr, 8'h00);

    cyc(0, 0, 1, 0, 8'h0F);
    cyc(0, 0, 1, 1, 8'hF0);
    cyc(0, 0, 1, 0, 8'hAA);
    chk("ocw1_imr_AA", imr, 8'hAA);
    chk("ismr_keeps_F0", ismr, 8'hF0);
    cyc(0, 0, 0, 1, 8'h00);
    cyc(0, 0, 0, 0, 8'h33);
    cyc(0, 0, 0, 1, 8'h77);
    chk("mode_toggle_imr", imr, 8'hAA);
    chk("mode_toggle_ismr", ismr, 8'hF0);

    cyc(0, 1, 1, 0, 8'h55);
    chk("icw1_wins_imr", imr, 8'h00);
    chk("icw1_wins_ismr", ismr, 8'h00);

    // Strobe held three cycles: last bus and mode win.
    cyc(0, 0, 1, 1, 8'h11);
    cyc(0, 0, 1, 0, 8'h22);
    cyc(0, 0, 1, 0, 8'h33);
    chk("held_imr", imr, 8'h33);
    chk("held_ismr", ismr, 8'h11);

    cyc(1, 0, 1, 0, 8'hFF);
    chk("reset_wins_imr", imr, 8'h00);
    chk("reset_wins_ismr", ismr, 8'h00);
    cyc(0, 0, 1, 1, 8'hC3);
    cyc(1, 0, 1, 1, 8'hFF);
    chk("reset_wins_ismr2", ismr, 8'h00);

    // Pseudo-random traffic, checked by the model comparison only.
    for (int k = 0; k < 60; k++) begin
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
          $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ocw1_mask_registers.md
Name: ocw1_mask_registers

Overview:
- Holds the 8259A interrupt mask register (IMR) and the interrupt special mask register (ISMR). Both are loaded from Operation Control Word 1 (OCW1) writes.
- Sits inside the control-logic section of the PIC, between the internal data bus / write decode and the priority resolver.
- ICW1 initialisation clears both registers.
- Whether an OCW1 write lands in IMR or ISMR is set by the current special-mask-mode flag.

Parameters:
- DATA_WIDTH, 8, width of the internal data bus and of each mask register (one bit per IR line).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- write_initial_command_word_1  input  1  one-or-more-cycle strobe; ICW1 is being written.
- write_operation_control_word_1_registers  input  1  strobe; OCW1 data is being written.
- special_mask_mode  input  1  0 = OCW1 targets IMR; 1 = OCW1 targets ISMR.
- internal_data_bus  input  DATA_WIDTH  OCW1 data byte; bit n corresponds to IRn.
- interrupt_mask  output  DATA_WIDTH  IMR contents; 1 = IRn masked.
- interrupt_special_mask  output  DATA_WIDTH  ISMR contents; 1 = IRn special-masked.

Interface (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Both outputs come directly from flops. No combinational path from inputs to outputs.
- Register update priority each rising clock edge, highest first:
  1. reset=1: interrupt_mask <= 0, interrupt_special_mask <= 0.
  2. write_initial_command_word_1=1: both registers <= 0.
  3. write_operation_control_word_1_registers=1 and special_mask_mode=0: interrupt_mask <= internal_data_bus; ISMR holds.
  4. write_operation_control_word_1_registers=1 and special_mask_mode=1: interrupt_special_mask <= internal_data_bus; IMR holds.
  5. Otherwise both registers hold.
- Latency: new value visible the cycle after the edge where the strobe was sampled high.
- Strobes are level-sampled: a strobe held N cycles writes N times. The last sampled bus and mode values win.
- special_mask_mode is sampled on the same edge as the OCW1 strobe. A change of mode without a strobe never moves data between registers.
- ICW1 and OCW1 strobes high together: ICW1 wins, both registers cleared.
- Reset mid-write: reset wins; the write is lost.
- No X propagation: both registers are defined from the first reset onward.

Optional Feature:
- Macro OCW1_EFFECTIVE_MASK_EN.
- Defined: adds output effective_mask [DATA_WIDTH]. It is registered and updated on the same edge as the sources it depends on.
  - special_mask_mode=1: effective_mask = interrupt_mask | interrupt_special_mask.
  - special_mask_mode=0: effective_mask = interrupt_mask.
  - Reset and ICW1 clear it to 0.
- Undefined: port absent; all other behaviour identical.

Decomposition:
- Shared package pic8259_pkg holds:
  - localparam PIC_DATA_WIDTH = 8
  - typedef logic [PIC_DATA_WIDTH-1:0] pic_byte_t
  - constant PIC_MASK_CLEAR = '0
- Natural sub-module: pic_mask_reg, a DATA_WIDTH load/clear register with synchronous clear priority over load. It is instantiated twice (IMR and ISMR) with decoded load enables.

Test Plan:
- Reset for 2 cycles -> interrupt_mask=8'h00, interrupt_special_mask=8'h00.
- ICW1 strobe 1 cycle after the registers hold nonzero values -> both read 8'h00 next cycle.
- OCW1 strobe, special_mask_mode=0, bus=8'h0F -> interrupt_mask=8'h0F, interrupt_special_mask stays 8'h00.
- OCW1 strobe, special_mask_mode=1, bus=8'hF0 -> interrupt_special_mask=8'hF0, interrupt_mask stays 8'h0F.
- OCW1 strobe, special_mask_mode=0, bus=8'hAA -> interrupt_mask=8'hAA, ISMR stays 8'hF0. Then toggle mode without a strobe -> no change.
- ICW1 and OCW1 strobes together with bus=8'h55 -> both 8'h00.
- Reset together with OCW1 (bus=8'hFF) -> both 8'h00.
- With OCW1_EFFECTIVE_MASK_EN defined: IMR=8'h0F, ISMR=8'hF0, mode=1 -> effective_mask=8'hFF; mode=0 -> effective_mask=8'h0F.
